sbox_engine: RTL and testbench

Parametrised, sequential byte-substitution engine for the AES datapath. It accepts a SIZE-bit block and applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to every byte. The mode is selected per block. Only LANES S-box instances are shared across the block, one chunk per cycle, so area trades against latency. It sits between AddRoundKey and (Inv)ShiftRows in the round datapath and exchanges blocks with neighbours through valid/ready handshakes.

---
 rtl/sbox_engine.sv | 172 +++++++++++++++++
 tb/tb_sbox_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : sbox_engine
// Purpose  : Sequential AES byte-substitution engine. A SIZE-bit block is
//            accepted on a valid/ready handshake and every byte is replaced
//            by its forward (SubBytes) or inverse (InvSubBytes) S-box value.
//            LANES S-box lookups are shared across the block, so a block
//            takes BEATS = SIZE/(8*LANES) cycles. Chunk 0 is the most
//            significant LANES bytes.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready/inv/data_in   - upstream handshake + mode
//            out_valid/out_ready/data_out    - downstream handshake + result
//            busy                            - engine owns a block
// Revision : 1.0 - initial release
// ============================================================================
module sbox_engine #(
    parameter int SIZE  = 128,
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            inv,
    input  logic [SIZE-1:0] data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] data_out,
    output logic            busy
);

    localparam int BEATS   = (LANES > 0) ? SIZE / (8 * LANES) : 1;
    localparam int CHUNK_W = 8 * LANES;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    generate
        if ((SIZE % 8) != 0 || LANES < 1 || ((SIZE / 8) % LANES) != 0) begin : g_bad_cfg
            $error("sbox_engine: SIZE must be a multiple of 8 and SIZE/8 a multiple of LANES");
        end
    endgenerate

    // FIPS-197 tables, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry x starts at bit 8*(255-x); for an 8-bit x, 255-x is simply ~x.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return SBOX_INV_TBL[{~x, 3'b000} +: 8];
    endfunction

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               mode_q,  mode_d;
    logic [SIZE-1:0]    data_q,  data_d;

    logic [CHUNK_W-1:0] chunk_in;
    logic [CHUNK_W-1:0] chunk_out;

    // Select the chunk addressed by the beat counter.
    always_comb begin
        chunk_in = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                chunk_in = data_q[SIZE-1-b*CHUNK_W -: CHUNK_W];
            end
        end
    end

    // The LANES shared S-box lanes; mode comes from the latched register so
    // the inv input cannot disturb a block in flight.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [7:0] byte_in;
            assign byte_in = chunk_in[CHUNK_W-1-8*i -: 8];
            assign chunk_out[CHUNK_W-1-8*i -: 8] = mode_q ? sbox_inv(byte_in)
                                                          : sbox_fwd(byte_in);
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_BUSY;
                    data_d  = data_in;
                    mode_d  = inv;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                for (int b = 0; b < BEATS; b++) begin
                    if (cnt_q == CNT_W'(b)) begin
                        data_d[SIZE-1-b*CHUNK_W -: CHUNK_W] = chunk_out;
                    end
                end
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
        data_out  = data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_engine
// Purpose  : Self-checking bench for sbox_engine. One instance in the default
//            configuration (128/4) plus three sweep instances (128/16,
//            256/8, 256/1). Expected values come from a GF(2^8) reference
//            model of the S-box built at start-up and from fixed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance: SIZE=128, LANES=4
    logic         m_in_valid, m_in_ready, m_inv, m_out_valid, m_out_ready, m_busy;
    logic [127:0] m_data_in, m_data_out;
    // sweep instances
    logic         s1_in_valid, s1_in_ready, s1_inv, s1_out_valid, s1_out_ready, s1_busy;
    logic [127:0] s1_data_in, s1_data_out;
    logic         s2_in_valid, s2_in_ready, s2_inv, s2_out_valid, s2_out_ready, s2_busy;
    logic [255:0] s2_data_in, s2_data_out;
    logic         s3_in_valid, s3_in_ready, s3_inv, s3_out_valid, s3_out_ready, s3_busy;
    logic [255:0] s3_data_in, s3_data_out;

    sbox_engine #(.SIZE(128), .LANES(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .inv(m_inv), .data_in(m_data_in), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .data_out(m_data_out), .busy(m_busy));

    sbox_engine #(.SIZE(128), .LANES(16)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .inv(s1_inv), .data_in(s1_data_in), .out_valid(s1_out_valid),
        .out_ready(s1_out_ready), .data_out(s1_data_out), .busy(s1_busy));

    sbox_engine #(.SIZE(256), .LANES(8)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .inv(s2_inv), .data_in(s2_data_in), .out_valid(s2_out_valid),
        .out_ready(s2_out_ready), .data_out(s2_data_out), .busy(s2_busy));

    sbox_engine #(.SIZE(256), .LANES(1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .inv(s3_inv), .data_in(s3_data_in), .out_valid(s3_out_valid),
        .out_ready(s3_out_ready), .data_out(s3_data_out), .busy(s3_busy));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_vec(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model: S-box from GF(2^8) arithmetic -------
    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    task automatic build_model();
        logic [7:0] xi, s, xb, yb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            xi = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    yb = 8'(y);
                    if (gmul(xb, yb) == 8'h01) xi = yb;
                end
            end
            s = xi ^ rotl8(xi, 1) ^ rotl8(xi, 2) ^ rotl8(xi, 3) ^ rotl8(xi, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = xb;
        end
    endtask

    function automatic logic [255:0] ref_block(input logic [255:0] d, input logic m, input int size);
        logic [255:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < size / 8; i++) begin
            b = d[size-1-8*i -: 8];
            r[size-1-8*i -: 8] = m ? ref_inv[b] : ref_fwd[b];
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main-instance block transaction ----------------------
    task automatic run_main(input string name, input logic [127:0] din, input logic m,
                            input logic [127:0] exp, input bit scramble, input int hold);
        int lat;
        @(negedge clk);
        check_bit({name, " in_ready idle"}, m_in_ready, 1'b1);
        m_in_valid = 1'b1; m_data_in = din; m_inv = m;
        @(posedge clk);
        @(negedge clk);
        if (!scramble) m_in_valid = 1'b0;
        check_bit({name, " busy"}, m_busy, 1'b1);
        check_bit({name, " in_ready busy"}, m_in_ready, 1'b0);
        lat = 0;
        while (!m_out_valid && lat < 200) begin
            if (scramble) begin
                m_data_in = rand256()[127:0];
                m_inv = ~m_inv;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        m_in_valid = 1'b0;
        check_int({name, " latency"}, lat, 4);
        check_vec({name, " data"}, {128'h0, m_data_out}, {128'h0, exp});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_bit({name, " hold out_valid"}, m_out_valid, 1'b1);
            check_bit({name, " hold in_ready"}, m_in_ready, 1'b0);
            check_vec({name, " hold data"}, {128'h0, m_data_out}, {128'h0, exp});
        end
        m_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_out_ready = 1'b0;
        check_bit({name, " in_ready after xfer"}, m_in_ready, 1'b1);
        check_bit({name, " out_valid after xfer"}, m_out_valid, 1'b0);
        check_bit({name, " busy after xfer"}, m_busy, 1'b0);
    endtask

    // ---------------- sweep-instance accessors -----------------------------
    task automatic set_sw(input int k, input logic v, input logic [255:0] d, input logic m);
        case (k)
            1: begin s1_in_valid = v; s1_data_in = d[127:0]; s1_inv = m; end
            2: begin s2_in_valid = v; s2_data_in = d; s2_inv = m; end
            default: begin s3_in_valid = v; s3_data_in = d; s3_inv = m; end
        endcase
    endtask

    task automatic set_sw_ready(input int k, input logic r);
        case (k)
            1: s1_out_ready = r;
            2: s2_out_ready = r;
            default: s3_out_ready = r;
        endcase
    endtask

    function automatic logic sw_ov(input int k);
        case (k)
            1: return s1_out_valid;
            2: return s2_out_valid;
            default: return s3_out_valid;
        endcase
    endfunction

    function automatic logic sw_ir(input int k);
        case (k)
            1: return s1_in_ready;
            2: return s2_in_ready;
            default: return s3_in_ready;
        endcase
    endfunction

    function automatic logic [255:0] sw_do(input int k);
        case (k)
            1: return {128'h0, s1_data_out};
            2: return s2_data_out;
            default: return s3_data_out;
        endcase
    endfunction

    task automatic run_sweep(input int k, input int size, input int beats, input int nblk);
        logic [255:0] d, exp;
        logic         m;
        int           lat, hold;
        string        name;
        for (int n = 0; n < nblk; n++) begin
            name = $sformatf("sweep%0d/%0d blk%0d", size, size / (8 * beats), n);
            d = rand256();
            if (size == 128) d[255:128] = '0;
            m = 1'($urandom_range(0, 1));
            exp = ref_block(d, m, size);
            @(negedge clk);
            check_bit({name, " in_ready"}, sw_ir(k), 1'b1);
            set_sw(k, 1'b1, d, m);
            @(posedge clk);
            @(negedge clk);
            set_sw(k, 1'b0, rand256(), ~m);
            lat = 0;
            while (!sw_ov(k) && lat < 200) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            check_int({name, " latency"}, lat, beats);
            check_vec({name, " data"}, sw_do(k), exp);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
            end
            check_vec({name, " data held"}, sw_do(k), exp);
            set_sw_ready(k, 1'b1);
            @(posedge clk);
            @(negedge clk);
            set_sw_ready(k, 1'b0);
        end
    endtask

    typedef struct {
        logic [127:0] din;
        logic         m;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [127:0] d;
        logic         mm;
        m_in_valid = 0; m_inv = 0; m_data_in = '0; m_out_ready = 0;
        s1_in_valid = 0; s1_inv = 0; s1_data_in = '0; s1_out_ready = 0;
        s2_in_valid = 0; s2_inv = 0; s2_data_in = '0; s2_out_ready = 0;
        s3_in_valid = 0; s3_inv = 0; s3_data_in = '0; s3_out_ready = 0;

        vecs[0] = '{128'hD42711AEE0BF98F1B8B45DE51E415230, 1'b1,
                    128'h193DE3BEA0F4E22B9AC68D2AE9F84808, 0};
        vecs[1] = '{128'h193DE3BEA0F4E22B9AC68D2AE9F84808, 1'b0,
                    128'hD42711AEE0BF98F1B8B45DE51E415230, 0};
        vecs[2] = '{128'h0, 1'b0, {16{8'h63}}, 0};
        vecs[3] = '{{16{8'h53}}, 1'b0, {16{8'hED}}, 0};
        vecs[4] = '{128'h0, 1'b1, {16{8'h52}}, 5};

        build_model();

        // reset state, observed while rst_n is still low
        #12;
        check_bit("reset in_ready", m_in_ready, 1'b1);
        check_bit("reset out_valid", m_out_valid, 1'b0);
        check_bit("reset busy", m_busy, 1'b0);
        check_vec("reset data_out", {128'h0, m_data_out}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_main($sformatf("vec%0d", i), vecs[i].din, vecs[i].m, vecs[i].exp, 1'b0, vecs[i].hold);
        end

        // inputs scrambled while busy; result must follow the accepted block
        for (int i = 0; i < 3; i++) begin
            d = rand256()[127:0];
            mm = 1'($urandom_range(0, 1));
            run_main($sformatf("scramble%0d", i), d, mm, ref_block({128'h0, d}, mm, 128)[127:0], 1'b1, 0);
        end

        // back-to-back forward then inverse
        d = rand256()[127:0];
        run_main("b2b fwd", d, 1'b0, ref_block({128'h0, d}, 1'b0, 128)[127:0], 1'b0, 0);
        d = rand256()[127:0];
        run_main("b2b inv", d, 1'b1, ref_block({128'h0, d}, 1'b1, 128)[127:0], 1'b0, 0);

        // asynchronous reset at beat 2
        @(negedge clk);
        m_in_valid = 1'b1; m_data_in = rand256()[127:0]; m_inv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("midrst out_valid", m_out_valid, 1'b0);
        check_bit("midrst in_ready", m_in_ready, 1'b1);
        check_bit("midrst busy", m_busy, 1'b0);
        check_vec("midrst data_out", {128'h0, m_data_out}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_main("after reset", {16{8'h63}}, 1'b1, 128'h0, 1'b0, 0);

        // parameter sweep against the reference model
        run_sweep(1, 128, 1, 6);
        run_sweep(2, 256, 4, 6);
        run_sweep(3, 256, 32, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
